bcd_seg_encoder: RTL and testbench
==================================

# bcd_seg_encoder

Sequential binary-to-display encoder directly upstream of the four-digit seven-segment scan controller. Accepts a 14-bit unsigned value on a start strobe and converts it to four BCD digits with an iterative shift-add-3 (double-dabble) loop. It then drives four registered, active-low segment patterns (`dis_a`..`dis_d`) straight into the controller's digit inputs. Outputs hold the last completed result, so the scanned display never shows intermediate values.

## Interface
- `VALUE_W`, 14: input value width; fixed range 0..9999 displayable.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request conversion of `value`; sampled only in IDLE.
- `value`  in  14  unsigned binary value to display.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when `dis_*` have been updated.
- `ovf`  out  1  registered; high when the last converted value exceeded 9999.
- `dis_a`  out  7  thousands digit (leftmost), active-low `{g,f,e,d,c,b,a}`.
- `dis_b`  out  7  hundreds digit.
- `dis_c`  out  7  tens digit.
- `dis_d`  out  7  units digit (rightmost).

## Operation
- FSM states: IDLE, CONV, LATCH.
- IDLE, `start`=1:
  - load shift register `{16'b0, value}`;
  - iteration counter ← 0, `busy` ← 1, overflow flag ← (`value` > 9999);
  - go to CONV.
- IDLE, `start`=0: no change.
- CONV, per cycle:
  - each BCD nibble ≥ 5 gets +3;
  - then the 30-bit register shifts left by 1;
  - counter increments.
  - After the 14th shift, go to LATCH.
- LATCH:
  - encode the four nibbles, register them to `dis_a`..`dis_d`;
  - `ovf` ← overflow flag, `done` ← 1, `busy` ← 0;
  - go to IDLE.
- Digit encoding, active-low:
  - 0 = 7'b100_0000, 1 = 7'b111_1001, 2 = 7'b010_0100, 3 = 7'b011_0000, 4 = 7'b001_1001;
  - 5 = 7'b001_0010, 6 = 7'b000_0010, 7 = 7'b111_1000, 8 = 7'b000_0000, 9 = 7'b001_0000;
  - blank = 7'b111_1111, dash = 7'b011_1111.
- Overflow (value 10000..16383): all four digits show dash; `ovf`=1.
- `start` while `busy`: ignored, never queued.
- `value` is sampled only at the accepting edge; later changes have no effect.
- `rst` at any time, including mid-CONV:
  - state ← IDLE;
  - `dis_a`..`dis_d` = 7'b111_1111;
  - `busy`=0, `done`=0, `ovf`=0;
  - no `done` is issued for the aborted conversion.

## Timing
- Edge E0: `start` accepted; `busy` high after E0.
- E1..E14: one iteration each.
- E15: outputs updated, `done`=1 for exactly the cycle after E15, `busy`=0 in that same cycle.
- Latency from accepting edge to valid outputs: 15 cycles.
- Minimum start-to-start period: 16 cycles. `start` held high during the `done` cycle is accepted at E16.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `LEADING_ZERO_BLANK_EN`:
  - Defined: in LATCH, leading zero digits (`dis_a`, then `dis_b`, then `dis_c`) are blanked while all more-significant digits are zero. `dis_d` always shows a digit, so 0 displays as blank-blank-blank-0.
  - Undefined: all four digits are always shown, so 7 displays as 0007.
  - Overflow dashes are unaffected in both builds.

## Structure
- Shared package `seg_pkg` holds:
  - segment constants `SEG_0`..`SEG_9`, `SEG_BLANK`, `SEG_DASH`;
  - FSM state encoding;
  - `BCD_MAX` = 9999.
- Sub-module `bcd_to_seg`: combinational 4-bit BCD to 7-bit active-low pattern, with a `blank` input. Instantiated four times in LATCH.

## Test plan
- Reset: assert `rst` 2 cycles → `dis_a`..`dis_d`=7'h7F, `busy`=0, `done`=0, `ovf`=0.
- `value`=1234, `start` pulse → after exactly 15 edges `done`=1 one cycle with `dis_a`=7'b111_1001, `dis_b`=7'b010_0100, `dis_c`=7'b011_0000, `dis_d`=7'b001_1001, `ovf`=0.
- `value`=7 and `value`=0, both builds:
  - with `LEADING_ZERO_BLANK_EN`: `dis_a`..`dis_c`=7'h7F, `dis_d`=7'b111_1000 / 7'b100_0000;
  - without: leading digits = 7'b100_0000.
- `value`=10000 → all four `dis_*`=7'b011_1111, `ovf`=1. Then `value`=9999 → all 7'b001_0000, `ovf`=0.
- `start` re-pulsed at cycles 3 and 10 of a conversion with a different `value` → ignored; single `done`; outputs reflect the first value.
- `rst` at cycle 8 of a conversion → no `done`, outputs blank, `busy`=0. A new `start` afterwards completes normally in 15 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the binary-to-seven-segment encoder: active-low
// glyphs {g,f,e,d,c,b,a}, FSM state encoding and the BCD helper.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b100_0000;
   localparam logic [6:0] SEG_1     = 7'b111_1001;
   localparam logic [6:0] SEG_2     = 7'b010_0100;
   localparam logic [6:0] SEG_3     = 7'b011_0000;
   localparam logic [6:0] SEG_4     = 7'b001_1001;
   localparam logic [6:0] SEG_5     = 7'b001_0010;
   localparam logic [6:0] SEG_6     = 7'b000_0010;
   localparam logic [6:0] SEG_7     = 7'b111_1000;
   localparam logic [6:0] SEG_8     = 7'b000_0000;
   localparam logic [6:0] SEG_9     = 7'b001_0000;
   localparam logic [6:0] SEG_BLANK = 7'b111_1111;
   localparam logic [6:0] SEG_DASH  = 7'b011_1111;

   localparam int unsigned BCD_MAX    = 9999;
   localparam int unsigned BCD_DIGITS = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CONV  = 2'd1,
      ST_LATCH = 2'd2
   } state_t;

   // Double-dabble correction: a nibble of 5 or more would exceed 9 after
   // the next doubling, so pre-add 3 to carry into the next decade.
   function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
      return (nib >= 4'd5) ? nib + 4'd3 : nib;
   endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment glyph; codes above 9
// render as a dash, and `blank` overrides everything.
module bcd_to_seg
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (blank) begin
         seg = SEG_BLANK;
      end else begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/bcd_seg_encoder.sv
// Iterative (double-dabble) binary to four-digit seven-segment encoder with
// registered, hold-last-result outputs. Optional LEADING_ZERO_BLANK_EN blanks leading zeros.
module bcd_seg_encoder
   import seg_pkg::*;
#(
   parameter int unsigned VALUE_W = 14
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [VALUE_W-1:0] value,
   output logic               busy,
   output logic               done,
   output logic               ovf,
   output logic [6:0]         dis_a,
   output logic [6:0]         dis_b,
   output logic [6:0]         dis_c,
   output logic [6:0]         dis_d
);

   localparam int unsigned        BCD_W     = 4 * BCD_DIGITS;
   localparam int unsigned        SR_W      = BCD_W + VALUE_W;
   localparam int unsigned        CNT_W     = $clog2(VALUE_W + 1);
   localparam logic [CNT_W-1:0]   LAST_ITER = CNT_W'(VALUE_W - 1);
   localparam logic [VALUE_W-1:0] VALUE_MAX = VALUE_W'(BCD_MAX);

   state_t             state, state_nxt;
   logic [SR_W-1:0]    sr, sr_adj;
   logic [CNT_W-1:0]   iter;
   logic               ovf_flag;

   logic [3:0]         nib_th, nib_hu, nib_te, nib_un;
   logic               blank_th, blank_hu, blank_te;
   logic [6:0]         seg_th, seg_hu, seg_te, seg_un;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_CONV;
         ST_CONV:  if (iter == LAST_ITER) state_nxt = ST_LATCH;
         ST_LATCH: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ---------------- shift-add-3 ----------------
   always_comb begin
      sr_adj = sr;
      for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
         sr_adj[VALUE_W + 4*i +: 4] = bcd_adjust(sr[VALUE_W + 4*i +: 4]);
      end
   end

   // ---------------- digit decode ----------------
   always_comb begin
      nib_th = sr[VALUE_W + 12 +: 4];
      nib_hu = sr[VALUE_W + 8  +: 4];
      nib_te = sr[VALUE_W + 4  +: 4];
      nib_un = sr[VALUE_W      +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      // Each blank chains on the more-significant digit being blank too.
      blank_th = (nib_th == 4'd0);
      blank_hu = blank_th && (nib_hu == 4'd0);
      blank_te = blank_hu && (nib_te == 4'd0);
`else
      blank_th = 1'b0;
      blank_hu = 1'b0;
      blank_te = 1'b0;
`endif
   end

   bcd_to_seg u_seg_th (.bcd(nib_th), .blank(blank_th), .seg(seg_th));
   bcd_to_seg u_seg_hu (.bcd(nib_hu), .blank(blank_hu), .seg(seg_hu));
   bcd_to_seg u_seg_te (.bcd(nib_te), .blank(blank_te), .seg(seg_te));
   bcd_to_seg u_seg_un (.bcd(nib_un), .blank(1'b0),     .seg(seg_un));

   // ---------------- datapath and output registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sr       <= '0;
         iter     <= '0;
         ovf_flag <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ovf      <= 1'b0;
         dis_a    <= SEG_BLANK;
         dis_b    <= SEG_BLANK;
         dis_c    <= SEG_BLANK;
         dis_d    <= SEG_BLANK;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sr       <= {{BCD_W{1'b0}}, value};
                  iter     <= '0;
                  busy     <= 1'b1;
                  ovf_flag <= (value > VALUE_MAX);
               end
            end
            ST_CONV: begin
               sr   <= sr_adj << 1;
               iter <= iter + CNT_W'(1);
            end
            ST_LATCH: begin
               // Out-of-range inputs leave truncated BCD in sr; show dashes instead.
               dis_a <= ovf_flag ? SEG_DASH : seg_th;
               dis_b <= ovf_flag ? SEG_DASH : seg_hu;
               dis_c <= ovf_flag ? SEG_DASH : seg_te;
               dis_d <= ovf_flag ? SEG_DASH : seg_un;
               ovf   <= ovf_flag;
               done  <= 1'b1;
               busy  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_seg_encoder.sv
// Self-checking bench for bcd_seg_encoder: directed scenarios plus random
// values checked against a decimal-arithmetic reference model.
module tb_bcd_seg_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [13:0] value = '0;
   logic        busy, done, ovf;
   logic [6:0]  dis_a, dis_b, dis_c, dis_d;

   int checks = 0;
   int errors = 0;

   logic [6:0] glyph [10] = '{7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000,
                              7'b001_1001, 7'b001_0010, 7'b000_0010, 7'b111_1000,
                              7'b000_0000, 7'b001_0000};

   bcd_seg_encoder #(.VALUE_W(14)) dut (
      .clk(clk), .rst(rst), .start(start), .value(value),
      .busy(busy), .done(done), .ovf(ovf),
      .dis_a(dis_a), .dis_b(dis_b), .dis_c(dis_c), .dis_d(dis_d)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // Reference: decimal digits by division, display rules applied directly.
   function automatic logic [27:0] model(input int v);
      int         d [4];
      logic [6:0] s [4];
      if (v > 9999) return {4{7'b011_1111}};
      d[0] = v / 1000;
      d[1] = (v / 100) % 10;
      d[2] = (v / 10) % 10;
      d[3] = v % 10;
      for (int i = 0; i < 4; i++) s[i] = glyph[d[i]];
`ifdef LEADING_ZERO_BLANK_EN
      if (v < 1000) s[0] = 7'h7F;
      if (v < 100)  s[1] = 7'h7F;
      if (v < 10)   s[2] = 7'h7F;
`endif
      return {s[0], s[1], s[2], s[3]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input int v);
      value = 14'(v);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (done) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({dis_a, dis_b, dis_c, dis_d} !== 28'hFFFFFFF) begin
         errors++;
         $display("FAIL reset_dis: got %h expected %h", {dis_a, dis_b, dis_c, dis_d}, 28'hFFFFFFF);
      end
      checks++;
      if ({busy, done, ovf} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got busy/done/ovf=%b expected 000", {busy, done, ovf});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_1234();
      int cyc;
      launch(1234);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL busy_after_accept: got busy=%b done=%b expected busy=1 done=0", busy, done);
      end
      wait_done(cyc);
      checks++;
      if (cyc !== 15) begin
         errors++;
         $display("FAIL latency_1234: got %0d expected 15", cyc);
      end
      checks++;
      if ({dis_a, dis_b, dis_c, dis_d} !== {7'b111_1001, 7'b010_0100, 7'b011_0000, 7'b001_1001}) begin
         errors++;
         $display("FAIL dis_1234: got %h expected %h", {dis_a, dis_b, dis_c, dis_d},
                  {7'b111_1001, 7'b010_0100, 7'b011_0000, 7'b001_1001});
      end
      checks++;
      if (ovf !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL flags_1234: got ovf=%b busy=%b expected 0 0", ovf, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_width: got done=%b one cycle later expected 0", done);
      end
   endtask

   task automatic test_small();
      int         cyc;
      int         vals [2] = '{7, 0};
      logic [6:0] unit [2] = '{7'b111_1000, 7'b100_0000};
      logic [27:0] exp;
      for (int k = 0; k < 2; k++) begin
         launch(vals[k]);
         wait_done(cyc);
`ifdef LEADING_ZERO_BLANK_EN
         exp = {7'h7F, 7'h7F, 7'h7F, unit[k]};
`else
         exp = {7'b100_0000, 7'b100_0000, 7'b100_0000, unit[k]};
`endif
         checks++;
         if (cyc !== 15 || {dis_a, dis_b, dis_c, dis_d} !== exp) begin
            errors++;
            $display("FAIL small_%0d: got lat=%0d dis=%h expected lat=15 dis=%h",
                     vals[k], cyc, {dis_a, dis_b, dis_c, dis_d}, exp);
         end
      end
   endtask

   task automatic test_overflow();
      int cyc;
      int vals [3] = '{10000, 9999, 16383};
      logic [27:0] exp [3] = '{{4{7'b011_1111}}, {4{7'b001_0000}}, {4{7'b011_1111}}};
      logic        eovf [3] = '{1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
         launch(vals[k]);
         wait_done(cyc);
         checks++;
         if ({dis_a, dis_b, dis_c, dis_d} !== exp[k] || ovf !== eovf[k]) begin
            errors++;
            $display("FAIL range_%0d: got dis=%h ovf=%b expected dis=%h ovf=%b",
                     vals[k], {dis_a, dis_b, dis_c, dis_d}, ovf, exp[k], eovf[k]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int n_done = 0;
      int done_at = -1;
      launch(4821);
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (done) begin
            n_done++;
            done_at = c;
         end
         start = (c == 2 || c == 9);
         if (c == 2) value = 14'd356;
      end
      start = 1'b0;
      checks++;
      if (n_done !== 1 || done_at !== 15) begin
         errors++;
         $display("FAIL ignore_start: got %0d done(s) at cycle %0d expected 1 at 15", n_done, done_at);
      end
      checks++;
      if ({dis_a, dis_b, dis_c, dis_d} !== model(4821)) begin
         errors++;
         $display("FAIL ignore_value: got %h expected %h", {dis_a, dis_b, dis_c, dis_d}, model(4821));
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      int n_done = 0;
      launch(12000);
      wait_done(cyc);
      launch(5678);
      for (int c = 1; c < 8; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({dis_a, dis_b, dis_c, dis_d} !== 28'hFFFFFFF || {busy, done, ovf} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid: got dis=%h busy/done/ovf=%b expected %h 000",
                  {dis_a, dis_b, dis_c, dis_d}, {busy, done, ovf}, 28'hFFFFFFF);
      end
      for (int c = 0; c < 20; c++) begin
         tick();
         if (done) n_done++;
      end
      checks++;
      if (n_done !== 0) begin
         errors++;
         $display("FAIL aborted_done: got %0d done pulse(s) expected 0", n_done);
      end
      launch(42);
      wait_done(cyc);
      checks++;
      if (cyc !== 15 || {dis_a, dis_b, dis_c, dis_d} !== model(42)) begin
         errors++;
         $display("FAIL after_reset: got lat=%0d dis=%h expected lat=15 dis=%h",
                  cyc, {dis_a, dis_b, dis_c, dis_d}, model(42));
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int v1 = $urandom_range(0, 9999);
      int v2 = $urandom_range(0, 9999);
      launch(v1);
      wait_done(cyc);
      checks++;
      if ({dis_a, dis_b, dis_c, dis_d} !== model(v1)) begin
         errors++;
         $display("FAIL b2b_first: got %h expected %h", {dis_a, dis_b, dis_c, dis_d}, model(v1));
      end
      value = 14'(v2);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept: got busy=%b after E16 expected 1", busy);
      end
      wait_done(cyc);
      checks++;
      if (cyc !== 15 || {dis_a, dis_b, dis_c, dis_d} !== model(v2)) begin
         errors++;
         $display("FAIL b2b_second: got lat=%0d dis=%h expected lat=15 dis=%h",
                  cyc, {dis_a, dis_b, dis_c, dis_d}, model(v2));
      end
   endtask

   task automatic test_random();
      int cyc;
      int v;
      for (int k = 0; k < 25; k++) begin
         v = ($urandom_range(0, 3) == 0) ? $urandom_range(10000, 16383) : $urandom_range(0, 9999);
         launch(v);
         wait_done(cyc);
         checks++;
         if (cyc !== 15 || {dis_a, dis_b, dis_c, dis_d} !== model(v) || ovf !== (v > 9999)) begin
            errors++;
            $display("FAIL random_%0d: got lat=%0d dis=%h ovf=%b expected lat=15 dis=%h ovf=%b",
                     v, cyc, {dis_a, dis_b, dis_c, dis_d}, ovf, model(v), (v > 9999));
         end
         repeat ($urandom_range(0, 3)) tick();
      end
   endtask

   initial begin
      test_reset();
      test_1234();
      test_small();
      test_overflow();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
